// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-side program counter unit.
package pc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } pc_state_t;

  typedef enum logic [1:0] {
    NONE,
    BR,
    EXC
  } redir_cause_t;

  localparam int unsigned WORD_INC = 1;

endpackage

// File: rtl/pc_hist_buf.sv
// Ring buffer of recently fetched word PCs with a saturating entry count.
// Index 0 is the newest entry; indices at or beyond the count read as zero.
module pc_hist_buf #(
  parameter int DEPTH = 8,
  parameter int W     = 30
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW:0] CNT_MAX = (IW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [IW-1:0] wr_ptr_q, wr_ptr_d;
  logic [IW:0]   count_q, count_d;
  logic [IW-1:0] rd_addr;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
      if (count_q != CNT_MAX) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count masks entries never written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_addr = wr_ptr_q - rd_idx - IW'(1);
  assign rd_data = ({1'b0, rd_idx} < count_q) ? mem_q[rd_addr] : '0;
  assign count   = count_q;

endmodule

// File: rtl/pc_unit.sv
// Program counter with fetch handshake, prioritised redirects, freeze buffer and halt.
// Define PC_HIST_EN to add the fetched-PC history ring and its hist_* ports.
module pc_unit
  import pc_pkg::*;
#(
  parameter int                 ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  RESET_VEC  = 'h2FFC,
  parameter int                 HIST_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          os_ready,
  input  logic                          pc_en,
  output logic                          fetch_valid,
  input  logic                          fetch_ready,
  output logic [ADDR_W-3:0]             fetch_pc,
  input  logic                          br_valid,
  input  logic [ADDR_W-3:0]             br_target,
  input  logic                          exc_valid,
  input  logic [ADDR_W-3:0]             exc_vector,
  input  logic                          halt_req,
`ifdef PC_HIST_EN
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_rd_idx,
  output logic [ADDR_W-3:0]             hist_rd_pc,
  output logic [$clog2(HIST_DEPTH):0]   hist_count,
`endif
  output logic                          halted,
  output logic                          pc_upd
);

  localparam int PC_W = ADDR_W - 2;
  localparam logic [PC_W-1:0] RESET_PC = RESET_VEC[ADDR_W-1:2];

  if (HIST_DEPTH < 2 || (HIST_DEPTH & (HIST_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pc_unit: HIST_DEPTH must be a power of two >= 2");
  end

  pc_state_t    state_q, state_d;
  redir_cause_t pend_q, pend_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pend_pc_q, pend_pc_d;
  logic fetch_valid_q, fetch_valid_d;
  logic halted_q, halted_d;
  logic pc_upd_q, pc_upd_d;
  logic redir_take;
  logic accept;

  assign accept = fetch_valid_q & fetch_ready & pc_en;

  // Halt is checked before the accept so a halting cycle never consumes a request.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_pc_d  = pend_pc_q;
    redir_take = 1'b0;
    if (!os_ready) begin
      state_d = IDLE;
      pc_d    = RESET_PC;
      pend_d  = NONE;
    end else begin
      case (state_q)
        IDLE: state_d = RUN;
        RUN: begin
          if (pc_en) begin
            if (exc_valid) begin
              pc_d       = exc_vector;
              redir_take = 1'b1;
            end else if (br_valid) begin
              pc_d       = br_target;
              redir_take = 1'b1;
            end else if (pend_q != NONE) begin
              pc_d       = pend_pc_q;
              redir_take = 1'b1;
            end else if (halt_req) begin
              state_d = HALT;
            end else if (accept) begin
              pc_d = pc_q + PC_W'(WORD_INC);
            end
            pend_d = NONE;
          end else if (exc_valid) begin
            pend_d    = EXC;
            pend_pc_d = exc_vector;
          end else if (br_valid && pend_q != EXC) begin
            pend_d    = BR;
            pend_pc_d = br_target;
          end
        end
        HALT: begin
          if (pc_en) begin
            if (exc_valid) begin
              state_d    = RUN;
              pc_d       = exc_vector;
              redir_take = 1'b1;
            end else if (pend_q == EXC) begin
              state_d    = RUN;
              pc_d       = pend_pc_q;
              redir_take = 1'b1;
            end else if (!halt_req) begin
              state_d = RUN;
            end
            pend_d = NONE;
          end else if (exc_valid) begin
            pend_d    = EXC;
            pend_pc_d = exc_vector;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    fetch_valid_d = (state_d == RUN);
    halted_d      = (state_d == HALT);
    pc_upd_d      = os_ready & (redir_take | (pc_d != pc_q));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      pend_q        <= NONE;
      pend_pc_q     <= '0;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      pc_upd_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_q        <= pend_d;
      pend_pc_q     <= pend_pc_d;
      fetch_valid_q <= fetch_valid_d;
      halted_q      <= halted_d;
      pc_upd_q      <= pc_upd_d;
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_pc    = pc_q;
  assign halted      = halted_q;
  assign pc_upd      = pc_upd_q;

`ifdef PC_HIST_EN
  logic hist_wr;

  // A redirect still records the request it accepted; a halt never accepts.
  assign hist_wr = accept & (state_d == RUN);

  pc_hist_buf #(
    .DEPTH (HIST_DEPTH),
    .W     (PC_W)
  ) u_hist (
    .clk     (clk),
    .reset   (reset),
    .clr     (~os_ready),
    .wr_en   (hist_wr),
    .wr_data (pc_q),
    .rd_idx  (hist_rd_idx),
    .rd_data (hist_rd_pc),
    .count   (hist_count)
  );
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit; history checks are built when PC_HIST_EN is defined.
module tb_pc_unit;

  localparam int PC_W = 30;

  logic clk = 1'b0;
  logic reset;
  logic os_ready, pc_en, fetch_ready, br_valid, exc_valid, halt_req;
  logic [PC_W-1:0] br_target, exc_vector;
  logic fetch_valid, halted, pc_upd;
  logic [PC_W-1:0] fetch_pc;
`ifdef PC_HIST_EN
  logic [2:0] hist_rd_idx;
  logic [PC_W-1:0] hist_rd_pc;
  logic [3:0] hist_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  pc_unit dut (
    .clk         (clk),
    .reset       (reset),
    .os_ready    (os_ready),
    .pc_en       (pc_en),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_pc    (fetch_pc),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .exc_valid   (exc_valid),
    .exc_vector  (exc_vector),
    .halt_req    (halt_req),
`ifdef PC_HIST_EN
    .hist_rd_idx (hist_rd_idx),
    .hist_rd_pc  (hist_rd_pc),
    .hist_count  (hist_count),
`endif
    .halted      (halted),
    .pc_upd      (pc_upd)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs, then settle just past the next rising edge.
  task automatic applyStimulus(input logic os_r, input logic en, input logic rdy,
                               input logic br, input logic [PC_W-1:0] brt,
                               input logic exc, input logic [PC_W-1:0] excv,
                               input logic hlt);
    os_ready    = os_r;
    pc_en       = en;
    fetch_ready = rdy;
    br_valid    = br;
    br_target   = brt;
    exc_valid   = exc;
    exc_vector  = excv;
    halt_req    = hlt;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
`ifdef PC_HIST_EN
    hist_rd_idx = '0;
`endif
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, '0, 0, '0, 0);
    applyStimulus(0, 0, 0, 0, '0, 0, '0, 0);
    checkOutput("rst_valid", fetch_valid, 0);
    checkOutput("rst_pc", fetch_pc, 'hBFF);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_upd", pc_upd, 0);
    reset = 1'b0;

    applyStimulus(1, 1, 1, 0, '0, 0, '0, 0);
    checkOutput("boot_pc", fetch_pc, 'hBFF);
    checkOutput("boot_valid", fetch_valid, 1);
    checkOutput("boot_upd", pc_upd, 0);
    applyStimulus(1, 1, 1, 0, '0, 0, '0, 0);
    checkOutput("acc1_pc", fetch_pc, 'hC00);
    checkOutput("acc1_upd", pc_upd, 1);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, 0, '0, 0, '0, 0);
      checkOutput("bp_pc", fetch_pc, 'hC00);
      checkOutput("bp_valid", fetch_valid, 1);
      checkOutput("bp_upd", pc_upd, 0);
    end
    applyStimulus(1, 1, 1, 0, '0, 0, '0, 0);
    checkOutput("acc2_pc", fetch_pc, 'hC01);
    applyStimulus(1, 1, 1, 0, '0, 0, '0, 0);
    checkOutput("acc3_pc", fetch_pc, 'hC02);
    checkOutput("acc3_upd", pc_upd, 1);

    applyStimulus(1, 1, 1, 1, 'h100, 1, 'h40, 0);
    checkOutput("both_redir_pc", fetch_pc, 'h40);
    checkOutput("both_redir_upd", pc_upd, 1);
    applyStimulus(1, 1, 1, 0, '0, 0, '0, 0);
    checkOutput("after_redir_pc", fetch_pc, 'h41);

    applyStimulus(1, 0, 1, 1, 'h200, 0, '0, 0);
    checkOutput("frz_br_pc", fetch_pc, 'h41);
    checkOutput("frz_br_valid", fetch_valid, 1);
    checkOutput("frz_br_upd", pc_upd, 0);
    applyStimulus(1, 0, 1, 0, '0, 1, 'h80, 0);
    checkOutput("frz_exc_pc", fetch_pc, 'h41);
    applyStimulus(1, 0, 1, 0, '0, 0, '0, 0);
    checkOutput("frz_idle_pc", fetch_pc, 'h41);
    applyStimulus(1, 1, 1, 0, '0, 0, '0, 0);
    checkOutput("pend_apply_pc", fetch_pc, 'h80);
    checkOutput("pend_apply_upd", pc_upd, 1);
    applyStimulus(1, 1, 1, 0, '0, 0, '0, 0);
    checkOutput("pend_seq_pc", fetch_pc, 'h81);

    applyStimulus(1, 0, 1, 0, '0, 1, 'h90, 0);
    applyStimulus(1, 0, 1, 1, 'h300, 0, '0, 0);
    checkOutput("frz2_pc", fetch_pc, 'h81);
    applyStimulus(1, 1, 1, 0, '0, 0, '0, 0);
    checkOutput("exc_keeps_pend_pc", fetch_pc, 'h90);

    applyStimulus(1, 1, 1, 0, '0, 0, '0, 1);
    checkOutput("halt_halted", halted, 1);
    checkOutput("halt_valid", fetch_valid, 0);
    checkOutput("halt_pc", fetch_pc, 'h90);
    applyStimulus(1, 1, 1, 1, 'h500, 0, '0, 1);
    checkOutput("halt_br_pc", fetch_pc, 'h90);
    checkOutput("halt_br_halted", halted, 1);
    checkOutput("halt_br_upd", pc_upd, 0);
    applyStimulus(1, 1, 1, 0, '0, 1, 'h40, 1);
    checkOutput("halt_exc_halted", halted, 0);
    checkOutput("halt_exc_valid", fetch_valid, 1);
    checkOutput("halt_exc_pc", fetch_pc, 'h40);
    checkOutput("halt_exc_upd", pc_upd, 1);
    applyStimulus(1, 1, 1, 0, '0, 0, '0, 0);
    checkOutput("wake_seq_pc", fetch_pc, 'h41);

    applyStimulus(1, 1, 1, 0, '0, 0, '0, 1);
    checkOutput("halt2_pc", fetch_pc, 'h41);
    applyStimulus(1, 1, 1, 0, '0, 0, '0, 0);
    checkOutput("unhalt_halted", halted, 0);
    checkOutput("unhalt_pc", fetch_pc, 'h41);
    checkOutput("unhalt_upd", pc_upd, 0);
    applyStimulus(1, 1, 1, 0, '0, 0, '0, 0);
    checkOutput("unhalt_seq_pc", fetch_pc, 'h42);

    applyStimulus(1, 0, 1, 1, 'h200, 0, '0, 0);
    reset = 1'b1;
    applyStimulus(1, 1, 1, 0, '0, 0, '0, 0);
    checkOutput("midrst_pc", fetch_pc, 'hBFF);
    checkOutput("midrst_valid", fetch_valid, 0);
    reset = 1'b0;
    applyStimulus(1, 1, 1, 0, '0, 0, '0, 0);
    checkOutput("reboot_pc", fetch_pc, 'hBFF);
    applyStimulus(1, 1, 1, 0, '0, 0, '0, 0);
    checkOutput("pend_lost_pc", fetch_pc, 'hC00);

    applyStimulus(0, 1, 1, 0, '0, 0, '0, 0);
    checkOutput("osdrop_pc", fetch_pc, 'hBFF);
    checkOutput("osdrop_valid", fetch_valid, 0);
    checkOutput("osdrop_upd", pc_upd, 0);
    applyStimulus(1, 1, 1, 0, '0, 0, '0, 0);
    checkOutput("osrise_valid", fetch_valid, 1);

`ifdef PC_HIST_EN
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 0, '0, 0, '0, 0);
    checkOutput("hist_cnt3", hist_count, 3);
    hist_rd_idx = 3'd0;
    #1;
    checkOutput("hist3_idx0", hist_rd_pc, 'hC01);
    hist_rd_idx = 3'd3;
    #1;
    checkOutput("hist3_idx3_empty", hist_rd_pc, 0);
    for (int i = 0; i < 7; i++) applyStimulus(1, 1, 1, 0, '0, 0, '0, 0);
    checkOutput("hist_cnt_sat", hist_count, 8);
    hist_rd_idx = 3'd0;
    #1;
    checkOutput("hist_idx0", hist_rd_pc, 'hC08);
    hist_rd_idx = 3'd7;
    #1;
    checkOutput("hist_idx7", hist_rd_pc, 'hC01);
`endif

    applyStimulus(1, 1, 1, 0, '0, 1, 'h3FFF_FFFF, 0);
    checkOutput("top_pc", fetch_pc, 'h3FFF_FFFF);
    applyStimulus(1, 1, 1, 0, '0, 0, '0, 0);
    checkOutput("wrap_pc", fetch_pc, 0);
    checkOutput("wrap_upd", pc_upd, 1);

    applyStimulus(1, 1, 0, 1, '0, 0, '0, 0);
    checkOutput("eq_redir_pc", fetch_pc, 0);
    checkOutput("eq_redir_upd", pc_upd, 1);
    applyStimulus(1, 1, 0, 0, '0, 0, '0, 0);
    checkOutput("eq_redir_upd_clr", pc_upd, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
